abro_multi_fsm: RTL and testbench

- Parametrised N-input ABRO ("wait for all, then output, restart on R") controller.
- Latches N_IN level inputs in any order and any cycle grouping, then emits one registered pulse on o once every input has been seen.
- Then either waits for restart r or re-arms automatically.
- Adds an optional collection timeout, a per-input seen vector and a saturating emission counter for the status/debug path.

---
 rtl/abro_multi_fsm.sv | 94 +++++++++
 tb/tb_abro_multi_fsm.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/abro_multi_fsm.sv
// abro_multi_fsm: N-input ABRO controller with optional timeout, seen vector and saturating emit counter
module abro_multi_fsm #(
  parameter int N_IN       = 4,
  parameter int AUTO_REARM = 0,
  parameter int TIMEOUT    = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             r,
  output logic             o,
  output logic [1:0]       state,
  output logic [N_IN-1:0]  seen,
  output logic             timeout_p,
  output logic [CNT_W-1:0] emit_cnt
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE = 2'b00, COLLECT = 2'b01, EMIT = 2'b10, DONE = 2'b11} state_t;
  state_t            state_q, state_d;
  logic [N_IN-1:0]   seen_q, seen_d, acc;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tp_q, tp_d, o_q, done;
  // next-state: restart beats completion, completion beats timeout
  always_comb begin
    acc = seen_q | in_vec;
    done = &acc;
    state_d = state_q;
    seen_d = seen_q;
    timer_d = timer_q;
    tp_d = 1'b0;
    cnt_d = cnt_q;
    if (r) begin
      state_d = IDLE;
      seen_d = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = done ? EMIT : (|in_vec) ? COLLECT : IDLE;
          seen_d = done ? '1 : in_vec;
          timer_d = '0;
        end
        COLLECT: begin
          seen_d = acc;
          if (done) state_d = EMIT;
          else if (TIMEOUT != 0 && timer_q == T_LAST) begin
            state_d = IDLE;
            seen_d = '0;
            timer_d = '0;
            tp_d = 1'b1;
          end else timer_d = (TIMEOUT != 0) ? timer_q + 1'b1 : '0;
        end
        EMIT: begin
          state_d = (AUTO_REARM != 0) ? IDLE : DONE;
          seen_d = (AUTO_REARM != 0) ? '0 : '1;
          timer_d = '0;
        end
        DONE: seen_d = '1;
        default: begin
          state_d = IDLE;
          seen_d = '0;
          timer_d = '0;
        end
      endcase
    end
    if (state_d == EMIT && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      seen_q <= '0;
      timer_q <= '0;
      cnt_q <= '0;
      tp_q <= 1'b0;
      o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seen_q <= seen_d;
      timer_q <= timer_d;
      cnt_q <= cnt_d;
      tp_q <= tp_d;
      o_q <= (state_d == EMIT);
    end
  end
  assign o = o_q;
  assign state = state_q;
  assign seen = seen_q;
  assign timeout_p = tp_q;
  assign emit_cnt = cnt_q;
endmodule

// File: tb/tb_abro_multi_fsm.sv
// tb_abro_multi_fsm: scoreboard bench over three configurations of abro_multi_fsm
module tb_abro_multi_fsm;
  typedef struct {
    int         id;
    logic       o;
    logic [1:0] st;
    logic [3:0] sn;
    logic       tp;
    logic [7:0] cnt;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] iv[3];
  logic       rv[3];
  logic       o_w[3];
  logic [1:0] st_w[3];
  logic [3:0] sn_w[3];
  logic       tp_w[3];
  logic [7:0] c0, c1;
  logic [1:0] c2;
  exp_t       q[$];
  exp_t       e;
  logic [15:0] act, expv;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  abro_multi_fsm #(.N_IN(4), .AUTO_REARM(0), .TIMEOUT(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .in_vec(iv[0]), .r(rv[0]), .o(o_w[0]), .state(st_w[0]),
    .seen(sn_w[0]), .timeout_p(tp_w[0]), .emit_cnt(c0));
  abro_multi_fsm #(.N_IN(4), .AUTO_REARM(0), .TIMEOUT(3), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .in_vec(iv[1]), .r(rv[1]), .o(o_w[1]), .state(st_w[1]),
    .seen(sn_w[1]), .timeout_p(tp_w[1]), .emit_cnt(c1));
  abro_multi_fsm #(.N_IN(4), .AUTO_REARM(1), .TIMEOUT(0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_vec(iv[2]), .r(rv[2]), .o(o_w[2]), .state(st_w[2]),
    .seen(sn_w[2]), .timeout_p(tp_w[2]), .emit_cnt(c2));
  // monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      act = {o_w[e.id], st_w[e.id], sn_w[e.id], tp_w[e.id],
             (e.id == 0) ? c0 : (e.id == 1) ? c1 : {6'b0, c2}};
      expv = {e.o, e.st, e.sn, e.tp, e.cnt};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL chk%0d dut%0d got o=%b st=%b seen=%b tp=%b cnt=%0d want o=%b st=%b seen=%b tp=%b cnt=%0d",
                 checks, e.id, act[15], act[14:13], act[12:9], act[8], act[7:0],
                 e.o, e.st, e.sn, e.tp, e.cnt);
      end
    end
  end
  task automatic s(input int id, input logic [3:0] v, input logic rr, input logic eo,
                   input logic [1:0] est, input logic [3:0] esn, input logic etp, input int ecnt);
    exp_t x;
    iv[id] = v;
    rv[id] = rr;
    x = '{id, eo, est, esn, etp, 8'(ecnt)};
    q.push_back(x);
    @(negedge clk);
  endtask
  task automatic reset_mid();
    exp_t x;
    iv[0] = 4'b0000;
    rv[0] = 1'b0;
    x = '{0, 1'b0, 2'b00, 4'b0000, 1'b0, 8'd0};
    q.push_back(x);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 4'b0000;
      rv[i] = 1'b0;
    end
    s(0, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0);
    reset = 1'b0;
    s(1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0);
    s(2, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0);
    // dut0: ordered collection, DONE hold, restart
    s(0, 4'b0001, 0, 0, 2'b01, 4'b0001, 0, 0);
    s(0, 4'b0100, 0, 0, 2'b01, 4'b0101, 0, 0);
    s(0, 4'b0010, 0, 0, 2'b01, 4'b0111, 0, 0);
    s(0, 4'b1000, 0, 1, 2'b10, 4'b1111, 0, 1);
    s(0, 4'b0000, 0, 0, 2'b11, 4'b1111, 0, 1);
    s(0, 4'b0000, 0, 0, 2'b11, 4'b1111, 0, 1);
    s(0, 4'b1111, 0, 0, 2'b11, 4'b1111, 0, 1);
    s(0, 4'b0000, 1, 0, 2'b00, 4'b0000, 0, 1);
    s(0, 4'b1111, 0, 1, 2'b10, 4'b1111, 0, 2);
    s(0, 4'b0000, 0, 0, 2'b11, 4'b1111, 0, 2);
    s(0, 4'b0000, 1, 0, 2'b00, 4'b0000, 0, 2);
    // dut0: restart on the completing edge
    s(0, 4'b0101, 0, 0, 2'b01, 4'b0101, 0, 2);
    s(0, 4'b1010, 1, 0, 2'b00, 4'b0000, 0, 2);
    s(0, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 2);
    // dut0: duplicates and dropped bits stay latched
    s(0, 4'b0011, 0, 0, 2'b01, 4'b0011, 0, 2);
    s(0, 4'b0001, 0, 0, 2'b01, 4'b0011, 0, 2);
    s(0, 4'b0000, 0, 0, 2'b01, 4'b0011, 0, 2);
    s(0, 4'b1100, 0, 1, 2'b10, 4'b1111, 0, 3);
    s(0, 4'b0000, 0, 0, 2'b11, 4'b1111, 0, 3);
    s(0, 4'b0000, 1, 0, 2'b00, 4'b0000, 0, 3);
    // dut1: timeout after three COLLECT cycles
    s(1, 4'b0011, 0, 0, 2'b01, 4'b0011, 0, 0);
    s(1, 4'b0000, 0, 0, 2'b01, 4'b0011, 0, 0);
    s(1, 4'b0000, 0, 0, 2'b01, 4'b0011, 0, 0);
    s(1, 4'b0000, 0, 0, 2'b00, 4'b0000, 1, 0);
    s(1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0);
    // dut1: completion on the expiry cycle wins
    s(1, 4'b0011, 0, 0, 2'b01, 4'b0011, 0, 0);
    s(1, 4'b0000, 0, 0, 2'b01, 4'b0011, 0, 0);
    s(1, 4'b0000, 0, 0, 2'b01, 4'b0011, 0, 0);
    s(1, 4'b1100, 0, 1, 2'b10, 4'b1111, 0, 1);
    s(1, 4'b0000, 0, 0, 2'b11, 4'b1111, 0, 1);
    s(1, 4'b0000, 1, 0, 2'b00, 4'b0000, 0, 1);
    // dut2: auto re-arm with held inputs, 2-bit counter saturates
    s(2, 4'b1111, 0, 1, 2'b10, 4'b1111, 0, 1);
    s(2, 4'b1111, 0, 0, 2'b00, 4'b0000, 0, 1);
    s(2, 4'b1111, 0, 1, 2'b10, 4'b1111, 0, 2);
    s(2, 4'b1111, 0, 0, 2'b00, 4'b0000, 0, 2);
    s(2, 4'b1111, 0, 1, 2'b10, 4'b1111, 0, 3);
    s(2, 4'b1111, 0, 0, 2'b00, 4'b0000, 0, 3);
    s(2, 4'b1111, 0, 1, 2'b10, 4'b1111, 0, 3);
    s(2, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 3);
    // async reset in the middle of a collection
    s(0, 4'b0101, 0, 0, 2'b01, 4'b0101, 0, 3);
    reset_mid();
    s(0, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0);
    s(2, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
